// File: rtl/rf_pkg.sv
// Shared definitions for the 16x32 register file: widths, the register
// index type and the write-enable classification helpers.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int PC_IDX   = 15;
    localparam int NUM_REGS = 16;

    typedef logic [3:0] reg_idx_t;

    // Classification of the decoder's enable vector
    typedef enum logic [1:0] {
        WE_ZERO  = 2'd0,
        WE_ONE   = 2'd1,
        WE_MULTI = 2'd2
    } we_class_e;

    // Decide whether the enable vector is empty, one-hot or carries several bits
    function automatic we_class_e onehot16_check(input logic [15:0] we);
        int bitCount;
        bitCount = $countones(we);
        if (bitCount == 0) begin
            return WE_ZERO;
        end else if (bitCount == 1) begin
            return WE_ONE;
        end else begin
            return WE_MULTI;
        end
    endfunction

    // Position of the set bit; only meaningful when the vector is one-hot
    function automatic reg_idx_t onehot16_index(input logic [15:0] we);
        reg_idx_t idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (we[i]) begin
                idx = reg_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_cell.sv
// One storage register of the file: loads on enable, clears asynchronously.
module rf_cell #(
    parameter int W = rf_pkg::DATA_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Hold the value until enabled; reset wins at any time
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file_16x32.sv
// Sixteen-entry register file fed by the conditional write-enable decoder.
// R0-R14 are stored; reads of the PC index return the supplied PC+8 value
// and writes to it are dropped. Multi-hot enables never write anything and
// set a sticky error flag.
module reg_file_16x32 #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int PC_IDX = rf_pkg::PC_IDX
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [15:0]       WE,
    input  logic [DATA_W-1:0] WD,
    input  logic [3:0]        A1,
    input  logic [3:0]        A2,
    input  logic [3:0]        A3,
    input  logic [DATA_W-1:0] R15_IN,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] RD3,
    output logic              ERR_MULTI,
    output logic [3:0]        LAST_WIDX,
    output logic              LAST_VALID
);

    import rf_pkg::*;

    localparam reg_idx_t PC_IDX_V = reg_idx_t'(PC_IDX);

    we_class_e         w_weClass;
    reg_idx_t          w_widx;
    logic              w_commit;
    logic [DATA_W-1:0] w_regs [16];

    logic              r_errMulti;
    reg_idx_t          r_lastWidx;
    logic              r_lastValid;

    // Classify the enable vector and decide whether this edge commits a write
    always_comb begin
        w_weClass = onehot16_check(WE);
        w_widx    = onehot16_index(WE);
        w_commit  = (w_weClass == WE_ONE) && (w_widx != PC_IDX_V);
    end

    // Storage: the PC slot has no flops and reads as zero internally
    for (genvar gi = 0; gi < 16; gi++) begin : g_regs
        if (gi == PC_IDX) begin : g_pc
            assign w_regs[gi] = '0;
        end else begin : g_cell
            rf_cell #(
                .W (DATA_W)
            ) u_cell (
                .i_clk   (CLK),
                .i_rst_n (RST_N),
                .i_en    (w_commit && WE[gi]),
                .i_d     (WD),
                .o_q     (w_regs[gi])
            );
        end
    end

    // Track the most recent committed write and latch any multi-hot enable
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_errMulti  <= 1'b0;
            r_lastWidx  <= '0;
            r_lastValid <= 1'b0;
        end else begin
            if (w_commit) begin
                r_lastWidx  <= w_widx;
                r_lastValid <= 1'b1;
            end
            if (w_weClass == WE_MULTI) begin
                r_errMulti <= 1'b1;
            end
        end
    end

    // Three independent read ports; the PC index is redirected to R15_IN
    always_comb begin
        RD1 = (A1 == PC_IDX_V) ? R15_IN : w_regs[A1];
        RD2 = (A2 == PC_IDX_V) ? R15_IN : w_regs[A2];
        RD3 = (A3 == PC_IDX_V) ? R15_IN : w_regs[A3];
    end

    assign ERR_MULTI  = r_errMulti;
    assign LAST_WIDX  = r_lastWidx;
    assign LAST_VALID = r_lastValid;

endmodule

// File: tb/tb_reg_file_16x32.sv
// Scoreboard bench for reg_file_16x32: stimulus pushes the response a
// spec-level model predicts for the current cycle, a monitor pops it and
// compares against what the register file presents.
module tb_reg_file_16x32;

    logic        CLK;
    logic        RST_N;
    logic [15:0] WE;
    logic [31:0] WD;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic [3:0]  A3;
    logic [31:0] R15_IN;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] RD3;
    logic        ERR_MULTI;
    logic [3:0]  LAST_WIDX;
    logic        LAST_VALID;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] rd3;
        logic        err;
        logic [3:0]  lastWidx;
        logic        lastValid;
    } exp_t;

    exp_t        expQ [$];
    logic [31:0] mdlRegs [16];
    logic        mdlErr;
    logic [3:0]  mdlLastWidx;
    logic        mdlLastValid;
    int          testsRun;
    int          testsFailed;

    reg_file_16x32 dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .WE         (WE),
        .WD         (WD),
        .A1         (A1),
        .A2         (A2),
        .A3         (A3),
        .R15_IN     (R15_IN),
        .RD1        (RD1),
        .RD2        (RD2),
        .RD3        (RD3),
        .ERR_MULTI  (ERR_MULTI),
        .LAST_WIDX  (LAST_WIDX),
        .LAST_VALID (LAST_VALID)
    );

    // Free-running clock, period 10
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [3:0] a, input logic [31:0] pc);
        return (a == 4'd15) ? pc : mdlRegs[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mdlRegs[i] = 32'h0;
        mdlErr       = 1'b0;
        mdlLastWidx  = 4'd0;
        mdlLastValid = 1'b0;
    endtask

    // Drive one cycle of inputs, record the expected response, then advance the model across the edge
    task automatic applyStimulus(input logic rst, input logic [15:0] we, input logic [31:0] wd,
                                 input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                                 input logic [31:0] pc);
        exp_t e;
        int   ones;
        @(negedge CLK);
        #1;
        RST_N  = rst;
        WE     = we;
        WD     = wd;
        A1     = a1;
        A2     = a2;
        A3     = a3;
        R15_IN = pc;
        if (!rst) modelReset();
        e.rd1       = modelRead(a1, pc);
        e.rd2       = modelRead(a2, pc);
        e.rd3       = modelRead(a3, pc);
        e.err       = mdlErr;
        e.lastWidx  = mdlLastWidx;
        e.lastValid = mdlLastValid;
        expQ.push_back(e);
        if (rst) begin
            ones = $countones(we);
            if (ones > 1) begin
                mdlErr = 1'b1;
            end else if (ones == 1) begin
                for (int i = 0; i < 15; i++) begin
                    if (we[i]) begin
                        mdlRegs[i]   = wd;
                        mdlLastWidx  = 4'(i);
                        mdlLastValid = 1'b1;
                    end
                end
            end
        end
    endtask

    // Monitor: compare whatever the DUT shows against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("RD1", RD1, e.rd1);
                checkOutput("RD2", RD2, e.rd2);
                checkOutput("RD3", RD3, e.rd3);
                checkOutput("ERR_MULTI", {31'h0, ERR_MULTI}, {31'h0, e.err});
                checkOutput("LAST_WIDX", {28'h0, LAST_WIDX}, {28'h0, e.lastWidx});
                checkOutput("LAST_VALID", {31'h0, LAST_VALID}, {31'h0, e.lastValid});
            end
        end
    end

    initial begin
        logic [15:0] we;
        int          mode;
        int          waitCycles;
        testsRun    = 0;
        testsFailed = 0;
        RST_N  = 1'b0;
        WE     = 16'h0;
        WD     = 32'h0;
        A1     = 4'd0;
        A2     = 4'd0;
        A3     = 4'd0;
        R15_IN = 32'h0;
        modelReset();

        // Power-on reset, then release
        applyStimulus(1'b0, 16'h0, 32'h0, 4'd0, 4'd3, 4'd15, 32'h8);
        applyStimulus(1'b1, 16'h0, 32'h0, 4'd0, 4'd3, 4'd15, 32'h8);

        // R3 written, then asynchronous reset mid-run clears it immediately
        applyStimulus(1'b1, 16'h0008, 32'h1234, 4'd3, 4'd0, 4'd0, 32'h8);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd3, 4'd3, 4'd3, 32'h8);
        applyStimulus(1'b0, 16'h0008, 32'hFFFF, 4'd3, 4'd5, 4'd15, 32'h8);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd3, 4'd5, 4'd15, 32'h8);

        // Basic write/read: old value before the edge, new value after
        applyStimulus(1'b1, 16'h0008, 32'hDEADBEEF, 4'd3, 4'd0, 4'd0, 32'h8);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd3, 4'd0, 4'd0, 32'h8);

        // PC redirect and discarded R15 write
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd3, 4'd15, 4'd0, 32'h108);
        applyStimulus(1'b1, 16'h8000, 32'hFFFFFFFF, 4'd3, 4'd15, 4'd14, 32'h108);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd3, 4'd15, 4'd14, 32'h10C);

        // Condition-failed cycles leave R5 alone
        applyStimulus(1'b1, 16'h0020, 32'hA, 4'd5, 4'd3, 4'd15, 32'h10C);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0000, 32'h55, 4'd5, 4'd3, 4'd15, 32'h10C);

        // Multi-hot: nothing written, sticky error through legal writes
        applyStimulus(1'b1, 16'h0002, 32'h11, 4'd1, 4'd2, 4'd5, 32'h0);
        applyStimulus(1'b1, 16'h0006, 32'h77, 4'd1, 4'd2, 4'd5, 32'h0);
        applyStimulus(1'b1, 16'h0010, 32'h4, 4'd1, 4'd2, 4'd4, 32'h0);

        // Three-port read, including all ports on the same address
        applyStimulus(1'b1, 16'h0002, 32'h1, 4'd1, 4'd2, 4'd4, 32'h0);
        applyStimulus(1'b1, 16'h0004, 32'h2, 4'd1, 4'd2, 4'd4, 32'h0);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd1, 4'd2, 4'd4, 32'h0);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd4, 4'd4, 4'd4, 32'h0);

        // Reset clears the sticky error
        applyStimulus(1'b0, 16'h0000, 32'h0, 4'd1, 4'd2, 4'd4, 32'h0);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd1, 4'd2, 4'd4, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            mode = $urandom_range(0, 99);
            if (mode < 55)      we = 16'h1 << $urandom_range(0, 15);
            else if (mode < 80) we = 16'h0;
            else                we = 16'($urandom);
            applyStimulus((mode == 99) ? 1'b0 : 1'b1, we, $urandom,
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), $urandom);
        end
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'd0, 4'd7, 4'd14, 32'h0);

        // Let the monitor drain, bounded
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge CLK);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        #3;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
